// File: rtl/spi_master_bridge.sv
// spi_master_bridge
//   SPI mode-0 bus master that frames each transaction as a command byte
//   {we, adr[6:0]} followed by cmd_len_i data bytes, MSB first.
//
// Ports
//   clk_i, rst_ni              system clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o    command handshake; cmd_we_i/adr_i/len_i latched on accept
//   wd_valid_i/wd_ready_o      write byte stream; wd_data_i sampled when wd_ready_o is high
//   rd_valid_o/rd_ready_i      read byte stream; rd_data_o held until consumed
//   status_o                   byte received on MISO during the command byte
//   busy_o                     high from the cycle after accept until SSEL returns high
//   done_o                     one-cycle pulse in the first cycle SSEL is high again
//   SCK, SSEL, MOSI, MISO      SPI pins (CPOL=0, SSEL active low, MISO asynchronous)
//
// Handshake rule for every stream: a transfer happens on a rising clk_i edge
// where valid and ready are both high; valid never waits for ready, and a
// producer holds its data stable while valid is high and ready is low.
module spi_master_bridge #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned CS_LEAD  = 2,
    parameter int unsigned CS_TRAIL = 2,
    parameter int unsigned CS_IDLE  = 4,
    parameter int unsigned BYTE_GAP = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic       cmd_we_i,
    input  logic [6:0] cmd_adr_i,
    input  logic [7:0] cmd_len_i,
    input  logic       wd_valid_i,
    output logic       wd_ready_o,
    input  logic [7:0] wd_data_i,
    output logic       rd_valid_o,
    input  logic       rd_ready_i,
    output logic [7:0] rd_data_o,
    output logic [7:0] status_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       SCK,
    output logic       SSEL,
    output logic       MOSI,
    input  logic       MISO
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEAD, S_SHIFT, S_GAP, S_TRAIL
    } state_t;

    localparam int unsigned TW = 16;
    localparam logic [TW-1:0] T_DIV      = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0] T_LEAD     = TW'(CS_LEAD - 1);
    localparam logic [TW-1:0] T_TRAIL    = TW'(CS_TRAIL - 1);
    // After reset the full CS_IDLE count runs before cmd_ready_o rises; after a
    // transaction the accept cycle itself is the last of the CS_IDLE high cycles.
    localparam logic [TW-1:0] T_IDLE_RST = TW'(CS_IDLE);
    localparam logic [TW-1:0] T_IDLE     = TW'(CS_IDLE - 1);
    localparam logic [TW-1:0] T_GAP      = (BYTE_GAP == 0) ? '0 : TW'(BYTE_GAP - 1);

    state_t        state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;      // shared phase timer for every state
    logic          tmr_zero;
    logic [2:0]    bit_q;
    logic [7:0]    left_q;            // data bytes still to be shifted
    logic          first_q;           // byte in flight is the command byte
    logic          we_q;
    logic          sck_q, ssel_q, done_q;
    logic [7:0]    tx_q;
    logic [6:0]    rx_q;
    logic [7:0]    rx_byte;
    logic          miso_s1, miso_s2;
    logic [7:0]    status_q, rd_data_q;
    logic          rd_valid_q;
    logic          data_ok;
    logic          accept, load_data, phase_end, byte_end, trail_end;

    assign tmr_zero = (tmr_q == '0);
    assign rx_byte  = {rx_q, miso_s2};
    // A read byte may only start once the previous one has been consumed,
    // otherwise its capture would overwrite an unread rd_data_o.
    assign data_ok  = we_q ? wd_valid_i : !rd_valid_q;

    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        cmd_ready_o = 1'b0;
        accept      = 1'b0;
        load_data   = 1'b0;
        phase_end   = 1'b0;
        byte_end    = 1'b0;
        trail_end   = 1'b0;
        if (!tmr_zero) tmr_d = tmr_q - TW'(1);
        unique case (state_q)
            S_IDLE: begin
                cmd_ready_o = tmr_zero;
                if (tmr_zero && cmd_valid_i) begin
                    accept  = 1'b1;
                    state_d = S_LEAD;
                    tmr_d   = T_LEAD;
                end
            end
            S_LEAD: begin
                if (tmr_zero) begin
                    state_d = S_SHIFT;
                    tmr_d   = T_DIV;
                end
            end
            S_SHIFT: begin
                if (tmr_zero) begin
                    phase_end = 1'b1;
                    tmr_d     = T_DIV;
                    if (sck_q && bit_q == 3'd7) begin
                        byte_end = 1'b1;
                        if (left_q == 8'd0) begin
                            state_d = S_TRAIL;
                            tmr_d   = T_TRAIL;
                        end else if (BYTE_GAP == 0 && we_q && wd_valid_i) begin
                            // No gap configured: chain the next write byte directly.
                            load_data = 1'b1;
                        end else begin
                            state_d = S_GAP;
                            tmr_d   = T_GAP;
                        end
                    end
                end
            end
            S_GAP: begin
                if (tmr_zero && data_ok) begin
                    load_data = 1'b1;
                    state_d   = S_SHIFT;
                    tmr_d     = T_DIV;
                end
            end
            S_TRAIL: begin
                if (tmr_zero) begin
                    trail_end = 1'b1;
                    state_d   = S_IDLE;
                    tmr_d     = T_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            tmr_q      <= T_IDLE_RST;
            bit_q      <= 3'd0;
            left_q     <= 8'd0;
            first_q    <= 1'b0;
            we_q       <= 1'b0;
            sck_q      <= 1'b0;
            ssel_q     <= 1'b1;
            done_q     <= 1'b0;
            tx_q       <= 8'd0;
            rx_q       <= 7'd0;
            miso_s1    <= 1'b0;
            miso_s2    <= 1'b0;
            status_q   <= 8'd0;
            rd_data_q  <= 8'd0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            miso_s1 <= MISO;
            miso_s2 <= miso_s1;
            done_q  <= trail_end;
            if (accept) begin
                ssel_q  <= 1'b0;
                sck_q   <= 1'b0;
                bit_q   <= 3'd0;
                first_q <= 1'b1;
                we_q    <= cmd_we_i;
                left_q  <= cmd_len_i;
                tx_q    <= {cmd_we_i, cmd_adr_i};
            end
            if (trail_end) ssel_q <= 1'b1;
            if (phase_end) begin
                sck_q <= ~sck_q;
                // End of a high phase: sample MISO and advance MOSI while SCK drops.
                if (sck_q) begin
                    rx_q  <= rx_byte[6:0];
                    tx_q  <= {tx_q[6:0], 1'b0};
                    bit_q <= bit_q + 3'd1;
                end
            end
            if (byte_end) begin
                first_q <= 1'b0;
                if (first_q) status_q <= rx_byte;
                else if (!we_q) rd_data_q <= rx_byte;
            end
            if (load_data) begin
                tx_q   <= we_q ? wd_data_i : 8'h00;
                left_q <= left_q - 8'd1;
            end
            if (byte_end && !first_q && !we_q) rd_valid_q <= 1'b1;
            else if (rd_valid_q && rd_ready_i) rd_valid_q <= 1'b0;
        end
    end

    assign wd_ready_o = load_data && we_q;
    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_data_q;
    assign status_o   = status_q;
    assign busy_o     = (state_q != S_IDLE);
    assign done_o     = done_q;
    assign SCK        = sck_q;
    assign SSEL       = ssel_q;
    assign MOSI       = tx_q[7];

endmodule

// File: tb/tb_spi_master_bridge.sv
// tb_spi_master_bridge
//   Directed bench for spi_master_bridge with a mode-0 SPI slave model that
//   replays a response byte list on MISO and records MOSI bytes.
module tb_spi_master_bridge;

    localparam int CLK_DIV  = 4;
    localparam int CS_LEAD  = 2;
    localparam int CS_TRAIL = 2;
    localparam int CS_IDLE  = 4;
    localparam int BYTE_GAP = 8;

    // ---------------- clock / reset / DUT ----------------
    logic       clk_i       = 1'b0;
    logic       rst_ni      = 1'b0;
    logic       cmd_valid_i = 1'b0;
    logic       cmd_ready_o;
    logic       cmd_we_i    = 1'b0;
    logic [6:0] cmd_adr_i   = 7'd0;
    logic [7:0] cmd_len_i   = 8'd0;
    logic       wd_valid_i  = 1'b0;
    logic       wd_ready_o;
    logic [7:0] wd_data_i   = 8'd0;
    logic       rd_valid_o;
    logic       rd_ready_i  = 1'b0;
    logic [7:0] rd_data_o;
    logic [7:0] status_o;
    logic       busy_o, done_o;
    logic       SCK, SSEL, MOSI, MISO;

    spi_master_bridge #(
        .CLK_DIV (CLK_DIV),
        .CS_LEAD (CS_LEAD),
        .CS_TRAIL(CS_TRAIL),
        .CS_IDLE (CS_IDLE),
        .BYTE_GAP(BYTE_GAP)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .cmd_valid_i(cmd_valid_i),
        .cmd_ready_o(cmd_ready_o),
        .cmd_we_i   (cmd_we_i),
        .cmd_adr_i  (cmd_adr_i),
        .cmd_len_i  (cmd_len_i),
        .wd_valid_i (wd_valid_i),
        .wd_ready_o (wd_ready_o),
        .wd_data_i  (wd_data_i),
        .rd_valid_o (rd_valid_o),
        .rd_ready_i (rd_ready_i),
        .rd_data_o  (rd_data_o),
        .status_o   (status_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .SCK        (SCK),
        .SSEL       (SSEL),
        .MOSI       (MOSI),
        .MISO       (MISO)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- monitors and slave model ----------------
    int cyc = 0, sck_rises = 0, done_cnt = 0, acc_cnt = 0, wd_cnt = 0;
    int done_cyc = 0, acc_cyc = 0, ssel_run = 0, last_high_run = 0;
    logic [7:0] mosi_q[$];
    logic [7:0] rd_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] mosi_sh = 8'd0;
    int         mbits = 0;
    logic [5:0] sbit = 6'd0;
    logic [7:0] resp [8];
    logic [7:0] wd_buf [4];
    int         wd_idx = 0, wd_n = 0;

    always @(posedge clk_i) cyc++;
    always @(posedge SCK) sck_rises++;

    always @(negedge clk_i) begin
        if (done_o) begin done_cnt++; done_cyc = cyc; end
        if (cmd_valid_i && cmd_ready_o) begin acc_cnt++; acc_cyc = cyc; end
        if (wd_valid_i && wd_ready_o) wd_cnt++;
        if (rd_valid_o && rd_ready_i) rd_q.push_back(rd_data_o);
        if (SSEL) ssel_run++;
        else begin
            if (ssel_run != 0) last_high_run = ssel_run;
            ssel_run = 0;
        end
    end

    always @(posedge SCK or posedge SSEL) begin
        if (SSEL) mbits = 0;
        else begin
            mosi_sh = {mosi_sh[6:0], MOSI};
            mbits++;
            if (mbits == 8) begin mosi_q.push_back(mosi_sh); mbits = 0; end
        end
    end

    always @(negedge SCK or posedge SSEL) begin
        if (SSEL) sbit = 6'd0;
        else sbit = sbit + 6'd1;
    end

    assign MISO = SSEL ? 1'b0 : resp[sbit[5:3]][3'd7 - sbit[2:0]];

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Compares the bytes captured since 'start' against exp_q, then empties it.
    task automatic score_stream(input string tag, input int start, input bit is_rd);
        int n;
        logic [7:0] obs;
        n = is_rd ? rd_q.size() : mosi_q.size();
        check({tag, "_count"}, n - start, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            obs = 8'h00;
            if (start + i < n) obs = is_rd ? rd_q[start + i] : mosi_q[start + i];
            check($sformatf("%s_%0d", tag, i), obs, exp_q[i]);
        end
        exp_q.delete();
    endtask

    function automatic int exp_dur(input int len);
        return 1 + CS_LEAD + (1 + len) * 16 * CLK_DIV + len * BYTE_GAP + CS_TRAIL;
    endfunction

    // ---------------- driver tasks ----------------
    // One clock cycle; advances the write stream after a handshake.
    task automatic cycle();
        logic fire;
        @(negedge clk_i);
        fire = wd_valid_i && wd_ready_o;
        @(posedge clk_i);
        #1;
        if (fire) begin
            wd_idx++;
            if (wd_idx < wd_n) wd_data_i = wd_buf[wd_idx];
            else wd_valid_i = 1'b0;
        end
    endtask

    task automatic set_resp(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
        for (int i = 0; i < 8; i++) resp[i] = 8'h00;
        resp[0] = b0; resp[1] = b1; resp[2] = b2; resp[3] = b3;
    endtask

    task automatic load_wd(input int n, input logic [7:0] b0, input logic [7:0] b1, input bit present);
        wd_buf[0] = b0; wd_buf[1] = b1; wd_buf[2] = 8'h00; wd_buf[3] = 8'h00;
        wd_n = n; wd_idx = 0;
        wd_data_i = b0;
        wd_valid_i = present;
    endtask

    task automatic issue_cmd(input logic we, input logic [6:0] adr, input logic [7:0] len);
        int a0, n;
        a0 = acc_cnt; n = 0;
        cmd_we_i = we; cmd_adr_i = adr; cmd_len_i = len; cmd_valid_i = 1'b1;
        while (acc_cnt == a0 && n < 200) begin cycle(); n++; end
        cmd_valid_i = 1'b0;
        check("cmd_accept", acc_cnt - a0, 1);
    endtask

    task automatic wait_done(input int budget);
        int d0, n;
        d0 = done_cnt; n = 0;
        while (done_cnt == d0 && n < budget) begin cycle(); n++; end
        check("done_pulse", done_cnt - d0, 1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int m0, r0, s0, w0, d0, bad, hi;
        set_resp(8'h00, 8'h00, 8'h00, 8'h00);
        load_wd(0, 8'h00, 8'h00, 1'b0);

        // Reset values while rst_ni is low.
        #23;
        check("rst_pins_flags", {SSEL, SCK, MOSI, cmd_ready_o, wd_ready_o, rd_valid_o, busy_o, done_o},
              8'b1000_0000);
        check("rst_rd_data", rd_data_o, 8'h00);
        check("rst_status", status_o, 8'h00);
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (CS_IDLE - 1) @(negedge clk_i);
        check("rdy_before_idle", cmd_ready_o, 1'b0);
        @(negedge clk_i);
        check("rdy_after_idle", cmd_ready_o, 1'b1);
        @(posedge clk_i);
        #1;

        // Write: we=1 adr=0x12 len=2.
        set_resp(8'hA7, 8'h00, 8'h00, 8'h00);
        load_wd(2, 8'hA5, 8'h3C, 1'b1);
        m0 = mosi_q.size(); s0 = sck_rises; w0 = wd_cnt;
        issue_cmd(1'b1, 7'h12, 8'd2);
        wait_done(2000);
        exp_q.push_back(8'h92); exp_q.push_back(8'hA5); exp_q.push_back(8'h3C);
        score_stream("wr_mosi", m0, 1'b0);
        check("wr_sck_rises", sck_rises - s0, 24);
        check("wr_wd_pulses", wd_cnt - w0, 2);
        check("wr_status", status_o, 8'hA7);
        check("wr_duration", done_cyc - acc_cyc, exp_dur(2));
        check("wr_end_ssel_busy", {SSEL, busy_o}, 2'b10);

        // Read: we=0 adr=0x05 len=3, rd_ready_i high.
        repeat (CS_IDLE) cycle();
        set_resp(8'hA7, 8'h11, 8'h22, 8'h33);
        rd_ready_i = 1'b1;
        m0 = mosi_q.size(); r0 = rd_q.size(); w0 = wd_cnt;
        issue_cmd(1'b0, 7'h05, 8'd3);
        wait_done(2000);
        exp_q.push_back(8'h05); exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        score_stream("rd_mosi", m0, 1'b0);
        exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
        score_stream("rd_data", r0, 1'b1);
        check("rd_status", status_o, 8'hA7);
        check("rd_duration", done_cyc - acc_cyc, exp_dur(3));
        check("rd_no_wd", wd_cnt - w0, 0);

        // Read with backpressure after the first data byte.
        repeat (CS_IDLE) cycle();
        set_resp(8'hA7, 8'h11, 8'h22, 8'h33);
        rd_ready_i = 1'b0;
        r0 = rd_q.size(); s0 = sck_rises; d0 = done_cnt;
        issue_cmd(1'b0, 7'h05, 8'd3);
        bad = 0;
        while (!rd_valid_o && bad < 1000) begin cycle(); bad++; end
        check("bp_first_valid", rd_valid_o, 1'b1);
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            cycle();
            if (SCK !== 1'b0 || SSEL !== 1'b0 || rd_data_o !== 8'h11 || rd_valid_o !== 1'b1) bad++;
        end
        check("bp_stall_samples_bad", bad, 0);
        check("bp_sck_rises_held", sck_rises - s0, 16);
        check("bp_no_done", done_cnt - d0, 0);
        rd_ready_i = 1'b1;
        wait_done(2000);
        exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
        score_stream("bp_rd_data", r0, 1'b1);
        check("bp_sck_total", sck_rises - s0, 32);

        // Write underflow: data byte shows up 100 cycles after accept.
        repeat (CS_IDLE) cycle();
        set_resp(8'h5C, 8'h00, 8'h00, 8'h00);
        load_wd(1, 8'h5A, 8'h00, 1'b0);
        m0 = mosi_q.size(); s0 = sck_rises; w0 = wd_cnt;
        issue_cmd(1'b1, 7'h01, 8'd1);
        hi = 0;
        for (int i = 0; i < 100; i++) begin
            cycle();
            if (i >= 75 && SCK !== 1'b0) hi++;
        end
        check("uf_sck_low_in_gap", hi, 0);
        check("uf_sck_rises_held", sck_rises - s0, 8);
        check("uf_ssel_low", SSEL, 1'b0);
        wd_valid_i = 1'b1;
        wait_done(2000);
        exp_q.push_back(8'h81); exp_q.push_back(8'h5A);
        score_stream("uf_mosi", m0, 1'b0);
        check("uf_wd_pulses", wd_cnt - w0, 1);
        check("uf_status", status_o, 8'h5C);

        // len=0 back-to-back, with data streams offered but never used.
        load_wd(1, 8'hEE, 8'h00, 1'b1);
        rd_ready_i = 1'b1;
        set_resp(8'h3E, 8'h00, 8'h00, 8'h00);
        m0 = mosi_q.size(); r0 = rd_q.size(); s0 = sck_rises; w0 = wd_cnt;
        issue_cmd(1'b1, 7'h0A, 8'd0);
        wait_done(1000);
        check("l0a_duration", done_cyc - acc_cyc, exp_dur(0));
        check("l0a_sck_rises", sck_rises - s0, 8);
        issue_cmd(1'b1, 7'h0B, 8'd0);
        cycle();
        check("l0_idle_gap_ok", (last_high_run >= CS_IDLE), 1'b1);
        wait_done(1000);
        check("l0b_duration", done_cyc - acc_cyc, exp_dur(0));
        check("l0_sck_rises", sck_rises - s0, 16);
        check("l0_no_wd", wd_cnt - w0, 0);
        check("l0_no_rd", rd_q.size() - r0, 0);
        check("l0_status", status_o, 8'h3E);
        exp_q.push_back(8'h8A); exp_q.push_back(8'h8B);
        score_stream("l0_mosi", m0, 1'b0);
        wd_valid_i = 1'b0;

        // Reset during the 3rd bit of a read data byte.
        repeat (CS_IDLE) cycle();
        set_resp(8'hA7, 8'h11, 8'h00, 8'h00);
        s0 = sck_rises; d0 = done_cnt;
        issue_cmd(1'b0, 7'h22, 8'd1);
        bad = 0;
        while ((sck_rises - s0) < 11 && bad < 1000) begin cycle(); bad++; end
        check("rst_reach_bit3", sck_rises - s0, 11);
        check("rst_pre_sck_high", {SCK, SSEL}, 2'b10);
        #2;
        rst_ni = 1'b0;
        #1;
        check("rst_async_ssel_sck", {SSEL, SCK}, 2'b10);
        check("rst_async_rd_busy", {rd_valid_o, busy_o}, 2'b00);
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        repeat (CS_IDLE + 4) cycle();
        check("rst_no_done", done_cnt - d0, 0);
        check("rst_rd_valid", rd_valid_o, 1'b0);

        // A normal write completes after the reset.
        set_resp(8'hC3, 8'h00, 8'h00, 8'h00);
        load_wd(1, 8'h77, 8'h00, 1'b1);
        m0 = mosi_q.size();
        issue_cmd(1'b1, 7'h33, 8'd1);
        wait_done(2000);
        exp_q.push_back(8'hB3); exp_q.push_back(8'h77);
        score_stream("post_rst_mosi", m0, 1'b0);
        check("post_rst_duration", done_cyc - acc_cyc, exp_dur(1));
        check("post_rst_status", status_o, 8'hC3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_master_bridge.md
Name: spi_master_bridge

Overview:
- SPI bus master that initiates transactions for the team's SPI slave bridge.
- Frames every transaction as one command byte {we, adr[6:0]} followed by N data bytes.
- Generates SCK, SSEL and MOSI, and captures MISO.
- Sits between a host-side command/byte-stream interface (CPU, test sequencer) and the SPI pins to a remote slave.

Parameters:
- CLK_DIV, 4: SCK half-period in clk_i cycles; must be >= 3.
- CS_LEAD, 2: cycles from SSEL falling to the first SCK low phase; must be >= 1.
- CS_TRAIL, 2: cycles from the last SCK falling edge to SSEL rising; must be >= 1.
- CS_IDLE, 4: minimum number of cycles SSEL stays high between transactions; must be >= 1.
- BYTE_GAP, 8: SCK-low cycles inserted between bytes, giving the slave time to fetch from its bus; may be 0.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  reset, asynchronous assert, active-low.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  command accepted when both valid and ready are high.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_adr_i  in  7  slave register address.
- cmd_len_i  in  8  number of data bytes (0..255).
- wd_valid_i  in  1  write byte available.
- wd_ready_o  out  1  write byte consumed (1-cycle pulse).
- wd_data_i  in  8  write byte.
- rd_valid_o  out  1  read byte available; held until consumed.
- rd_ready_i  in  1  read byte consumed.
- rd_data_o  out  8  read byte.
- status_o  out  8  byte shifted in on MISO during the command byte (slave header/status).
- busy_o  out  1  transaction in progress.
- done_o  out  1  1-cycle pulse when SSEL returns high.
- SCK  out  1  SPI clock, CPOL=0.
- SSEL  out  1  active-low slave select.
- MOSI  out  1  master data out.
- MISO  in  1  slave data in; asynchronous, passed through a 2-flop synchroniser.

Behaviour:
- Reset values (asynchronous on rst_ni low):
  - SSEL=1, SCK=0, MOSI=0.
  - cmd_ready_o=0, wd_ready_o=0, rd_valid_o=0, rd_data_o=0, status_o=0, busy_o=0, done_o=0.
  - FSM in IDLE with the CS_IDLE counter preloaded, so cmd_ready_o rises CS_IDLE cycles after reset release.
- Reset mid-transfer: SSEL goes high immediately, all partial state is discarded, and no done_o is issued.
- SPI format: mode 0, MSB first. MOSI changes only while SCK is low. MISO is sampled from the synchronised value on the clk edge that ends each SCK high phase.
- FSM states and transitions:
  - IDLE: cmd_ready_o=1 once SSEL has been high for >= CS_IDLE cycles. On accept, latch we/adr/len; SSEL=0 and busy_o=1 from the next cycle; go to LEAD.
  - LEAD: lasts CS_LEAD cycles. Load shift register with {we, adr}. Go to SHIFT.
  - SHIFT: 8 bits, each one CLK_DIV cycles low then CLK_DIV cycles high, so one byte takes 16*CLK_DIV cycles. At the end of the byte:
    - command byte: capture into status_o;
    - read data byte: capture into rd_data_o and assert rd_valid_o;
    - write data byte: MISO is discarded.
    - Then go to GAP if bytes remain, else TRAIL.
  - GAP: SCK=0 for >= BYTE_GAP cycles. Leave only when both hold:
    - write: wd_valid_i=1 (load wd_data_i, pulse wd_ready_o); read: rd_valid_o=0, i.e. the previous byte has been consumed (load 0x00);
    - BYTE_GAP has elapsed.
    - Otherwise stretch with SCK held low; SSEL stays low indefinitely.
  - TRAIL: CS_TRAIL cycles, then SSEL=1, done_o pulse, busy_o=0, return to IDLE.
- cmd_len_i=0: command byte only (8 SCK pulses), no data-stream handshakes, then TRAIL.
- rd_valid_o/rd_ready_i: standard valid/ready handshake. The last read byte may still be pending after done_o; the next read may not overwrite it (GAP blocks).
- Unstalled duration, from the accept edge to done_o:
  - 1 + CS_LEAD + (1+len)*16*CLK_DIV + len*BYTE_GAP + CS_TRAIL cycles.
  - The first data byte of a write also waits in GAP.
- wd_data_i is sampled only in the cycle wd_ready_o pulses. cmd_* inputs are ignored while busy_o=1.

Test Plan:
- Write:
  - Stimulus: CLK_DIV=4; cmd we=1, adr=0x12, len=2; wd bytes 0xA5, 0x3C presented; slave model returns 0xA7 first.
  - Response: MOSI bytes 0x92, 0xA5, 0x3C; 24 SCK rising edges; two wd_ready_o pulses; status_o=0xA7; one done_o pulse.
- Read:
  - Stimulus: cmd we=0, adr=0x05, len=3; slave returns 0xA7, 0x11, 0x22, 0x33; rd_ready_i tied high.
  - Response: MOSI 0x05, 0x00, 0x00, 0x00; rd_data_o sequence 0x11, 0x22, 0x33; status_o=0xA7.
- Read backpressure:
  - Stimulus: same read with rd_ready_i=0 for 200 cycles after the first byte.
  - Response: SCK held low and SSEL low throughout the stall; rd_data_o stays 0x11; transfer resumes after the handshake; no byte lost.
- Write underflow:
  - Stimulus: write len=1 with wd_valid_i asserted 100 cycles late.
  - Response: SCK stays low in GAP until the byte arrives; MOSI byte correct.
- len=0:
  - Stimulus: command with cmd_len_i=0.
  - Response: exactly 8 SCK pulses; no wd/rd handshakes; done_o after CS_TRAIL; back-to-back commands keep SSEL high >= CS_IDLE cycles.
- Reset mid-transfer:
  - Stimulus: pulse rst_ni low during the 3rd bit of a data byte.
  - Response: SSEL=1 and SCK=0 asynchronously; rd_valid_o=0; no done_o; a subsequent command completes normally.
